// File: rtl/store_write_buffer.sv
// store_write_buffer
//   FIFO of retired stores waiting for the data cache. Stores are converted
//   to a word address, lane-aligned data and byte enables on entry, then
//   presented in order on the mem_* port. Misaligned SH/SW are dropped and
//   reported. Invalid store types are dropped silently.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        store request handshake from the pipeline
//   req_addr/req_data/req_type byte address, register data, store type
//   mem_valid/mem_ready        head-entry handshake toward the data cache
//   mem_addr/mem_wdata/mem_wbe word address, lane data, byte enables of head
//   misalign_err               one-cycle pulse after a misaligned store is dropped
//   misalign_addr              byte address of the most recent misaligned store
//   count, empty               occupancy, and occupancy == 0
module store_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [2:0]               req_type,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wbe,
  output logic                     misalign_err,
  output logic [31:0]              misalign_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    ST_SB = 3'b001,
    ST_SH = 3'b010,
    ST_SW = 3'b011
  } st_type_e;

  // Entry storage: word address only, the low two bits are always zero.
  logic [29:0]   ent_addr_q  [DEPTH];
  logic [29:0]   ent_addr_d  [DEPTH];
  logic [31:0]   ent_data_q  [DEPTH];
  logic [31:0]   ent_data_d  [DEPTH];
  logic [3:0]    ent_wbe_q   [DEPTH];
  logic [3:0]    ent_wbe_d   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_err_q, misalign_err_d;
  logic [31:0]   misalign_addr_q, misalign_addr_d;

  logic          accept;
  logic          legal;
  logic          misal;
  logic          enq;
  logic          deq;
  logic [3:0]    lane_wbe;
  logic [31:0]   lane_data;

  assign empty     = (count_q == '0);
  assign req_ready = (count_q < CW'(DEPTH));
  assign mem_valid = !empty;
  assign count     = count_q;

  assign mem_addr  = empty ? '0 : {ent_addr_q[head_q], 2'b00};
  assign mem_wdata = empty ? '0 : ent_data_q[head_q];
  assign mem_wbe   = empty ? '0 : ent_wbe_q[head_q];

  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;

  // Store-type decode and lane alignment.
  always_comb begin
    legal     = 1'b0;
    misal     = 1'b0;
    lane_wbe  = '0;
    lane_data = '0;
    case (req_type)
      ST_SB: begin
        legal     = 1'b1;
        lane_wbe  = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_data[7:0]}};
      end
      ST_SH: begin
        legal     = !req_addr[0];
        misal     = req_addr[0];
        lane_wbe  = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_data[15:0]}};
      end
      ST_SW: begin
        legal     = (req_addr[1:0] == 2'b00);
        misal     = (req_addr[1:0] != 2'b00);
        lane_wbe  = 4'b1111;
        lane_data = req_data;
      end
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign enq    = accept && legal;
  assign deq    = mem_valid && mem_ready;

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_wbe_d  = ent_wbe_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (enq) begin
      ent_addr_d[tail_q] = req_addr[31:2];
      ent_data_d[tail_q] = lane_data;
      ent_wbe_d[tail_q]  = lane_wbe;
      tail_d             = tail_q + PW'(1);
    end
    if (deq) begin
      head_d = head_q + PW'(1);
    end

    // Full buffer has req_ready low, so enq and deq never both occur at DEPTH.
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CW'(1);
    end

    misalign_err_d  = accept && misal;
    misalign_addr_d = (accept && misal) ? req_addr : misalign_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_wbe_q[i]  <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      ent_addr_q      <= ent_addr_d;
      ent_data_q      <= ent_data_d;
      ent_wbe_q       <= ent_wbe_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: stimulus pushes hand-computed expected cache
// writes into a queue; an independent monitor pops one entry for each write
// the DUT hands to the cache and compares it.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic [31:0]            req_data;
  logic [2:0]             req_type;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_wbe;
  logic                   misalign_err;
  logic [31:0]            misalign_addr;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_type     (req_type),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wbe      (mem_wbe),
    .misalign_err (misalign_err),
    .misalign_addr(misalign_addr),
    .count        (count),
    .empty        (empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one store and hold it until accepted (bounded). When push is set
  // the expected cache write is queued for the monitor.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input logic push, input logic [31:0] ea, input logic [31:0] ew,
                      input logic [3:0] eb);
    int unsigned n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_type  = t;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got req_ready=0 expected 1 for addr 0x%08h", a);
    end else if (push) begin
      e.addr  = ea;
      e.wdata = ew;
      e.wbe   = eb;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int unsigned n;
    n = 0;
    while (!empty && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", empty, 1);
  endtask

  // Monitor: one scoreboard pop per write handed to the cache.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h expected no write", mem_addr);
        end else begin
          mon_e = sb.pop_front();
          chk("mem_addr", mem_addr, mon_e.addr);
          chk("mem_wdata", mem_wdata, mon_e.wdata);
          chk("mem_wbe", {28'd0, mem_wbe}, {28'd0, mon_e.wbe});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_type  = '0;
    mem_ready = 1'b0;
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wbe", mem_wbe, 0);
    chk("rst_misalign_err", misalign_err, 0);
    chk("rst_misalign_addr", misalign_addr, 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // SB to byte lane 3, latency one cycle, then drains.
    mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h1003; req_data = 32'h0000_00A5; req_type = 3'b001;
    #1 chk("no_bypass", mem_valid, 0);
    send(32'h1003, 32'h0000_00A5, 3'b001, 1'b1, 32'h1000, 32'hA5A5_A5A5, 4'b1000);
    chk("sb_latency_valid", mem_valid, 1);
    @(posedge clk); #1;
    chk("sb_then_empty", empty, 1);

    // SH upper half, then a misaligned SW.
    send(32'h2002, 32'h1234_BEEF, 3'b010, 1'b1, 32'h2000, 32'hBEEF_BEEF, 4'b1100);
    send(32'h2001, 32'hDEAD_0001, 3'b011, 1'b0, '0, '0, '0);
    chk("sw_mis_err", misalign_err, 1);
    chk("sw_mis_addr", misalign_addr, 32'h2001);
    chk("sw_mis_count", count, 0);
    @(posedge clk); #1;
    chk("mis_err_one_cycle", misalign_err, 0);
    chk("mis_addr_hold", misalign_addr, 32'h2001);
    send(32'h3003, 32'h0000_5555, 3'b010, 1'b0, '0, '0, '0);
    chk("sh_mis_err", misalign_err, 1);
    chk("sh_mis_addr", misalign_addr, 32'h3003);
    chk("sh_mis_count", count, 0);

    // Invalid type is silently dropped while one entry waits.
    mem_ready = 1'b0;
    send(32'h4000, 32'hCAFE_F00D, 3'b011, 1'b1, 32'h4000, 32'hCAFE_F00D, 4'b1111);
    send(32'h5001, 32'h1111_2222, 3'b111, 1'b0, '0, '0, '0);
    chk("inv_count", count, 1);
    chk("inv_mis_err", misalign_err, 0);
    chk("inv_mem_valid", mem_valid, 1);
    chk("inv_head_stable", mem_addr, 32'h4000);
    chk("inv_mis_addr_kept", misalign_addr, 32'h3003);
    mem_ready = 1'b1;
    wait_empty();

    // Fill to DEPTH with the cache stalled; fifth store must wait.
    mem_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send(32'h100 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 3'b011, 1'b1,
               32'h100 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'b1111);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("full_count", count, 4);
        chk("full_req_ready", req_ready, 0);
        mem_ready = 1'b1;
        #1 chk("full_hold_ready", req_ready, 0);
      end
    join
    wait_empty();

    // Two queued, then enqueue and dequeue together for ten cycles.
    mem_ready = 1'b0;
    send(32'h200, 32'hA000_0000, 3'b011, 1'b1, 32'h200, 32'hA000_0000, 4'b1111);
    send(32'h204, 32'hA000_0001, 3'b011, 1'b1, 32'h204, 32'hA000_0001, 4'b1111);
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(32'h300 + 32'(4 * k), 32'hB000_0000 + 32'(k), 3'b011, 1'b1,
           32'h300 + 32'(4 * k), 32'hB000_0000 + 32'(k), 4'b1111);
      chk("steady_count", count, 2);
    end
    wait_empty();

    // Reset mid-cycle with three entries and a stalled head.
    mem_ready = 1'b0;
    send(32'h600, 32'h0000_0077, 3'b001, 1'b1, 32'h600, 32'h7777_7777, 4'b0001);
    send(32'h606, 32'hABCD_1234, 3'b010, 1'b1, 32'h604, 32'h1234_1234, 4'b1100);
    send(32'h608, 32'h0102_0304, 3'b011, 1'b1, 32'h608, 32'h0102_0304, 4'b1111);
    chk("pre_reset_count", count, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wbe", mem_wbe, 0);
    chk("arst_mis_addr", misalign_addr, 0);
    chk("arst_req_ready", req_ready, 1);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_reset_no_stale", mem_valid, 0);
    end
    send(32'h7001, 32'h0000_005A, 3'b001, 1'b1, 32'h7000, 32'h5A5A_5A5A, 4'b0010);
    wait_empty();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a store.
REQ-005 SHALL have port req_ready  output  1  buffer accepts a store this cycle.
REQ-006 SHALL have port req_addr  input  32  byte address of store.
REQ-007 SHALL have port req_data  input  32  register data; low byte/half used for SB/SH.
REQ-008 SHALL have port req_type  input  3  store type: 3'b001 SB, 3'b010 SH, 3'b011 SW, all others invalid.
REQ-009 SHALL have port mem_valid  output  1  head entry presented to data cache.
REQ-010 SHALL have port mem_ready  input  1  cache accepts head entry.
REQ-011 SHALL have port mem_addr  output  32  word address of head entry (bits [1:0] = 0).
REQ-012 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port mem_wbe  output  4  byte write enables, bit i = byte lane i (bits [8i+7:8i]).
REQ-014 SHALL have port misalign_err  output  1  one-cycle pulse: misaligned store dropped.
REQ-015 SHALL have port misalign_addr  output  32  address of most recent misaligned store.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-017 SHALL have port empty  output  1  high when count == 0 (used for fence/load ordering).

Function
REQ-018 SHALL drive req_ready = (count < DEPTH), combinationally from state only; no dependence on req_valid or mem_ready.
REQ-019 SHALL treat a request as accepted when req_valid && req_ready at a rising edge.
REQ-020 SHALL align SB: mem_wbe = 4'b0001 << addr[1:0], mem_wdata = {4{data[7:0]}}; never misaligned.
REQ-021 SHALL align SH: legal only when addr[0]==0; mem_wbe = addr[1] ? 4'b1100 : 4'b0011, mem_wdata = {2{data[15:0]}}.
REQ-022 SHALL align SW: legal only when addr[1:0]==0; mem_wbe = 4'b1111, mem_wdata = data.
REQ-023 SHALL store mem_addr as {addr[31:2], 2'b00} in the entry.
REQ-024 SHALL enqueue an accepted legal store at the tail; count increments unless a dequeue occurs the same edge.
REQ-025 SHALL on an accepted misaligned SH/SW not enqueue, and at the next edge set misalign_err=1 for exactly one cycle and load misalign_addr with req_addr.
REQ-026 SHALL on an accepted invalid req_type silently drop it: no enqueue, no error, count unchanged.
REQ-027 SHALL drive mem_valid = !empty; mem_addr/mem_wdata/mem_wbe from head entry, all zero when empty.
REQ-028 SHALL dequeue head when mem_valid && mem_ready at an edge; head fields stay stable while mem_valid && !mem_ready.
REQ-029 SHALL provide no bypass: a store accepted into an empty buffer appears on mem_* at earliest the following cycle (latency 1).
REQ-030 SHALL handle simultaneous enqueue and dequeue (0 < count < DEPTH) with count unchanged and both pointers advancing.
REQ-031 SHALL when full hold req_ready=0 even if mem_ready=1 that cycle; slot frees for next cycle.
REQ-032 SHALL wrap head/tail pointers modulo DEPTH; strict FIFO order to cache.
REQ-033 SHALL keep misalign_addr unchanged until the next misaligned store.

Reset
REQ-034 SHALL on rst_n=0, immediately and independent of clk: count=0, pointers=0, empty=1, mem_valid=0, mem_addr/mem_wdata/mem_wbe=0, misalign_err=0, misalign_addr=0.
REQ-035 SHALL discard all queued entries on reset mid-operation, including a head held by mem_ready=0; no partial write is presented after release.
REQ-036 SHALL resume accepting on the first edge after rst_n returns high (req_ready=1 throughout reset deassertion).

Verification
REQ-037 SB addr=0x1003 data=0x000000A5, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_wbe=4'b1000, mem_wdata=0xA5A5A5A5; then empty=1.
REQ-038 SH addr=0x2002 data=0x1234BEEF -> mem_wbe=4'b1100, mem_wdata=0xBEEFBEEF; SW addr=0x2001 -> no enqueue, misalign_err pulses 1 cycle, misalign_addr=0x2001.
REQ-039 mem_ready=0, 5 back-to-back SW (DEPTH=4) -> count reaches 4, req_ready=0, 5th held; raise mem_ready -> 5 writes drain in issue order.
REQ-040 count=2, simultaneous accept and dequeue every cycle for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-041 req_type=3'b111 accepted -> count unchanged, misalign_err=0, mem_valid unchanged.
REQ-042 3 entries queued, mem_ready=0, assert rst_n=0 mid-cycle -> mem_valid=0, count=0 immediately; after release no stale entry presented.
